// File: rtl/sig_frame_rx_pkg.sv
// Shared definitions for the 4-bit pattern generator and the serial frame receiver.
// Both stages import the pattern constants, so they always agree on the legal words.
package sig_frame_rx_pkg;

    localparam logic [3:0] PAT_M00 = 4'b1001;
    localparam logic [3:0] PAT_M01 = 4'b0110;
    localparam logic [3:0] PAT_M10 = 4'b0101;
    localparam logic [3:0] PAT_M11 = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } rx_state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_00 = 2'b00;
    localparam mode_t MODE_01 = 2'b01;
    localparam mode_t MODE_10 = 2'b10;
    localparam mode_t MODE_11 = 2'b11;

endpackage

// File: rtl/sig_word_decode.sv
// Combinational decode of a 4-bit frame word into its 2-bit mode code,
// a legality flag and a match flag against the configured MATCH word.
module sig_word_decode #(
    parameter logic [3:0] MATCH = 4'b0110
) (
    input  logic [3:0] word,
    output logic [1:0] mode,
    output logic       mode_ok,
    output logic       match
);
    import sig_frame_rx_pkg::*;

    // Illegal words fall back to mode 00 with mode_ok low.
    always_comb begin
        mode    = MODE_00;
        mode_ok = 1'b0;
        case (word)
            PAT_M00: begin
                mode    = MODE_00;
                mode_ok = 1'b1;
            end
            PAT_M01: begin
                mode    = MODE_01;
                mode_ok = 1'b1;
            end
            PAT_M10: begin
                mode    = MODE_10;
                mode_ok = 1'b1;
            end
            PAT_M11: begin
                mode    = MODE_11;
                mode_ok = 1'b1;
            end
            default: begin
                mode    = MODE_00;
                mode_ok = 1'b0;
            end
        endcase
    end

    assign match = (word == MATCH);

endmodule

// File: rtl/sig_frame_rx.sv
// Serial frame receiver: deserializes SIG/SYNC frames into 4-bit words, decodes the mode,
// and hands words to the consumer through a one-entry valid/ready holding register.
module sig_frame_rx #(
    parameter int         CW    = 8,
    parameter logic [3:0] MATCH = 4'b0110
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          SIG,
    input  logic          SYNC,
    input  logic          CLR,
    input  logic          WREADY,
    output logic [3:0]    WORD,
    output logic [1:0]    MODE,
    output logic          MODE_OK,
    output logic          WVALID,
    output logic          SEQ,
    output logic [CW-1:0] MATCH_CNT,
    output logic          FRAME_ERR,
    output logic          OVF
);
    import sig_frame_rx_pkg::*;

    localparam logic [CW-1:0] CNT_MAX = '1;

    rx_state_t   state;
    rx_state_t   next_state;
    logic [1:0]  idx;
    logic [1:0]  next_idx;
    logic [2:0]  shift;
    logic [2:0]  next_shift;
    logic        word_done;
    logic        frame_err_next;

    logic [3:0]  new_word;
    logic [1:0]  new_mode;
    logic        new_mode_ok;
    logic        new_match;
    logic        pop;
    logic        load;

    // Bit 3 is never stored: it is taken straight from SIG on the completing edge.
    assign new_word = {SIG, shift};
    assign pop      = WVALID & WREADY;
    assign load     = word_done & (~WVALID | pop);

    sig_word_decode #(
        .MATCH (MATCH)
    ) u_decode (
        .word    (new_word),
        .mode    (new_mode),
        .mode_ok (new_mode_ok),
        .match   (new_match)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            idx   <= 2'd0;
            shift <= 3'd0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            shift <= next_shift;
        end
    end

    // A SYNC seen mid-frame aborts the partial word and restarts from this cycle's bit.
    always_comb begin
        next_state     = state;
        next_idx       = idx;
        next_shift     = shift;
        word_done      = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (SYNC) begin
                    next_shift = {2'b00, SIG};
                    next_idx   = 2'd1;
                    next_state = RX;
                end
            end
            RX: begin
                if (SYNC) begin
                    frame_err_next = 1'b1;
                    next_shift     = {2'b00, SIG};
                    next_idx       = 2'd1;
                end else begin
                    case (idx)
                        2'd1: begin
                            next_shift[1] = SIG;
                            next_idx      = 2'd2;
                        end
                        2'd2: begin
                            next_shift[2] = SIG;
                            next_idx      = 2'd3;
                        end
                        2'd3: begin
                            word_done  = 1'b1;
                            next_idx   = 2'd0;
                            next_state = IDLE;
                        end
                        default: begin
                            next_idx   = 2'd0;
                            next_state = IDLE;
                        end
                    endcase
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = 2'd0;
            end
        endcase
    end

    // MODE/MODE_OK are captured with the word, so they always track the held WORD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WORD    <= 4'd0;
            MODE    <= 2'd0;
            MODE_OK <= 1'b0;
            WVALID  <= 1'b0;
        end else if (load) begin
            WORD    <= new_word;
            MODE    <= new_mode;
            MODE_OK <= new_mode_ok;
            WVALID  <= 1'b1;
        end else if (pop) begin
            WVALID  <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEQ       <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            SEQ       <= word_done & new_match;
            FRAME_ERR <= frame_err_next;
        end
    end

    // Dropped words still count toward the match statistics.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MATCH_CNT <= '0;
        end else if (CLR) begin
            MATCH_CNT <= '0;
        end else if (word_done && new_match && (MATCH_CNT != CNT_MAX)) begin
            MATCH_CNT <= MATCH_CNT + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF <= 1'b0;
        end else if (CLR) begin
            OVF <= 1'b0;
        end else if (word_done && WVALID && !pop) begin
            OVF <= 1'b1;
        end
    end

endmodule

// File: doc/sig_frame_rx.md
# sig_frame_rx

Serial frame receiver sitting directly downstream of the 4-bit pattern generator. It samples the generator's SIG/SYNC pair, deserializes each 4-bit frame and decodes it back to the 2-bit mode code. It flags pattern matches, framing errors and output overruns, and presents each word to the consumer over a valid/ready handshake through a one-entry holding register.

## Interface
- `CW`, 8: width of the saturating match counter.
- `MATCH`, 4'b0110: word value that raises SEQ and increments MATCH_CNT.
- `CLK` in 1: sole clock, all logic on rising edge.
- `RST_N` in 1: reset. One clock; reset is asynchronous and active-low.
- `SIG` in 1: serial data, one bit per cycle, bit 0 first.
- `SYNC` in 1: high in the same cycle as bit 0 of a frame.
- `CLR` in 1: synchronous clear of MATCH_CNT and OVF.
- `WREADY` in 1: consumer accepts WORD when WVALID & WREADY.
- `WORD` out 4: last completed word; WORD[k] = k-th received bit.
- `MODE` out 2: decoded mode of WORD.
- `MODE_OK` out 1: WORD is one of the four legal patterns.
- `WVALID` out 1: holding register full.
- `SEQ` out 1: one-cycle pulse when a completed word equals MATCH.
- `MATCH_CNT` out CW: count of words equal to MATCH, saturating.
- `FRAME_ERR` out 1: one-cycle pulse on a truncated frame.
- `OVF` out 1: sticky overrun flag.

## Operation
- The FSM has two states.
  - IDLE: SYNC=1 loads SIG into shift bit 0, sets idx=1 and moves to RX. SYNC=0 stays in IDLE and ignores SIG.
  - RX: each cycle stores SIG at bit idx.
    - At idx=3 the frame is complete: the word is formed, and the FSM returns to IDLE.
    - SYNC=1 while in RX (idx 1..3) pulses FRAME_ERR, discards the partial word, and restarts with this cycle's SIG as bit 0 (idx=1, stays RX).
- Back-to-back frames are supported with zero gap: SYNC on the cycle after bit 3 is a legal new frame.
- Mode decode of WORD is pure combinational on the held word:
  - 4'b1001 gives MODE 00.
  - 4'b0110 gives MODE 01.
  - 4'b0101 gives MODE 10.
  - 4'b1111 gives MODE 11.
  - Any other value gives MODE=00 and MODE_OK=0.
- Holding register behaviour on word completion:
  - Empty, or popped in the same cycle (WVALID & WREADY): the word loads and WVALID=1.
  - Full and not popped: the new word is dropped, OVF is set, and the held WORD is unchanged.
- A pop with no completion clears WVALID.
- SEQ and MATCH_CNT act on every completed word, including dropped ones.
- MATCH_CNT saturates at 2^CW−1.
- CLR clears MATCH_CNT and OVF. In the same cycle, CLR has priority over an increment or an OVF set.

## Timing
- Let E0 be the edge that samples SYNC=1 with bit 0; E1..E3 sample bits 1..3.
- After E3: WORD, MODE, MODE_OK and WVALID are updated, and SEQ is high for exactly one cycle. MATCH_CNT increments at E3.
- FRAME_ERR is high for the one cycle after the offending edge.
- Reset values:
  - FSM IDLE, idx=0, shift=0.
  - WORD=0, MODE=0, MODE_OK=0, WVALID=0, SEQ=0, FRAME_ERR=0, OVF=0, MATCH_CNT=0.
- Reset mid-frame discards the partial word. After release, the block waits for SYNC.
- SIG and SYNC are assumed synchronous to CLK (generated in the same domain); no synchronizer.

## Structure
- Shared package holds:
  - Pattern constants PAT_M00=4'b1001, PAT_M01=4'b0110, PAT_M10=4'b0101, PAT_M11=4'b1111.
  - The FSM state enum {IDLE, RX}.
  - Mode code type (2 bits).
- The generator also imports the pattern constants, so the two stages agree on the patterns.
- One sub-module, `sig_word_decode`: combinational WORD to {MODE, MODE_OK, match}. Everything else sits in the top.

## Test plan
- All four modes: send the four legal frames back-to-back (SYNC every 4 cycles), WREADY=1 → WORD 9,6,5,F with MODE 00,01,10,11 and MODE_OK=1. SEQ pulses only for 6. MATCH_CNT=1.
- Truncated frame: SYNC, 2 bits, then SYNC again followed by a full 0110 → FRAME_ERR pulses once, WORD=6, WVALID rises 4 cycles after the second SYNC.
- Overrun: WREADY=0, send 1001 then 1111 → WORD stays 9, OVF=1, WVALID=1. Raise WREADY for one cycle → WVALID=0 and OVF stays 1. Pulse CLR → OVF=0.
- Same-cycle pop and push: hold a word, assert WREADY exactly on the cycle a new 0110 completes → WVALID stays 1, WORD=6, OVF=0.
- Saturation and CLR priority: with CW=2, send 5 MATCH frames → MATCH_CNT=3. Assert CLR coincident with a 6th completion → MATCH_CNT=0.
- Reset mid-frame: drop RST_N after 2 bits → all outputs 0 immediately. After release, bits without SYNC produce no WVALID.
